uop_sequencer: RTL and testbench
================================

Name: uop_sequencer

Overview:
Sits between decode_unit and the execute stage. Accepts one decoded micro-op bundle per handshake: uop_0..uop_2 plus a count. Issues the bundle's micro-ops to the execute stage one per cycle, in address-generation-first order. Buffers up to QUEUE_DEPTH bundles and supports a synchronous flush on pipeline redirect.

Parameters:
UOP_W, 20, width of one micro-op word
QUEUE_DEPTH, 2, number of bundles buffered (legal values: 1 or 2)

Ports:
clk  in  1  clock
a_rst  in  1  reset, asynchronous, active-low
flush  in  1  synchronous discard of all buffered bundles (branch or PC redirect)
hold  in  1  global stall; freezes issue progress
feed_req  out  1  request to decoder; sequencer can accept a bundle
feed_ack  in  1  decoder delivers a bundle this cycle
uop_in_0  in  UOP_W  final micro-op (ALU or store)
uop_in_1  in  UOP_W  index/load micro-op
uop_in_2  in  UOP_W  pointer-load micro-op
uop_count_in  in  2  0: only uop_0; 1: uop_1 then uop_0; 2: uop_2, uop_1, uop_0
exu_ready  in  1  execute stage accepts a micro-op
uop_valid  out  1  uop_out is valid
uop_out  out  UOP_W  micro-op presented to execute
uop_step  out  2  index of the presented micro-op (2, 1 or 0)
uop_last  out  1  presented micro-op is uop_0 (end of bundle)
busy  out  1  at least one bundle buffered
seq_err  out  1  sticky: an illegal count was received

Behaviour:
- Reset values: queue empty, occupancy 0, step 0, seq_err 0. Hence uop_valid 0, uop_out 0, uop_step 0, uop_last 0, busy 0, feed_req 1.
- Push:
  - Occurs when feed_ack & feed_req & ~flush.
  - The bundle is stored at the tail with its step initialised to uop_count_in.
  - uop_count_in == 3 is stored as 2 and sets seq_err. seq_err is cleared only by reset.
  - feed_ack while feed_req == 0 is ignored and leaves the queue unchanged.
- feed_req = (occupancy < QUEUE_DEPTH) & ~flush.
  - It is derived from registered state and flush only.
  - There is no combinational path from exu_ready or hold.
- Presentation:
  - uop_valid = (occupancy != 0) & ~flush.
  - uop_out = head.uop[head.step], uop_step = head.step.
  - uop_last = uop_valid & (head.step == 0).
  - When uop_valid == 0, uop_out, uop_step and uop_last are driven 0.
- Transfer:
  - Occurs when uop_valid & exu_ready & ~hold.
  - On transfer with head.step > 0: head.step decrements.
  - On transfer with head.step == 0: the head bundle is popped and the next bundle, if any, becomes head on the following cycle.
- Latency: a bundle pushed into an empty queue is presented the next cycle. Issuing a bundle of count N takes N+1 transfer cycles.
- Throughput: with QUEUE_DEPTH 2, exu_ready held at 1 and back-to-back count-0 bundles, one micro-op issues per cycle with no bubbles.
- Simultaneous push and pop in one cycle:
  - Occupancy is unchanged.
  - When the queue is full, the push is not accepted, because feed_req was 0 that cycle.
- hold:
  - Blocks transfers, so step and head are unchanged.
  - Pushes are still accepted while feed_req is 1.
  - uop_valid stays asserted.
- flush:
  - Takes effect at the next clock edge: occupancy becomes 0, steps become 0 and any same-cycle push is dropped.
  - In the flush cycle itself, uop_valid is 0, so no transfer occurs.
  - flush overrides hold.
- QUEUE_DEPTH 1: feed_req is 0 whenever a bundle is buffered, giving a one-cycle bubble between bundles.
- Asynchronous reset mid-bundle: the queue empties immediately; the partially issued bundle is lost.

Decomposition:
- Shared package (cpu_pkg) holds:
  - UOP_W.
  - uop field bit positions: alu[19:16], carry_unmask[15], ld[14], wr[13], wflags[12], dest[11:8], wb[7], sel_k[6], regB[5:3], regA[2:0].
  - The bundle type: three uops plus a 2-bit step.
  - Step encodings STEP_PTR=2, STEP_IDX=1, STEP_FIN=0.
- Sub-module uop_bundle_fifo holds bundle storage, head/tail pointers, occupancy, and the head step register with its decrement.
- The top level holds the handshake, flush/hold gating, output mux and seq_err.

Test Plan:
- Reset, then push one bundle: count 0, uop_in_0=20'h70123, exu_ready 1. Required: next cycle uop_valid 1, uop_out 20'h70123, uop_last 1; following cycle busy 0.
- Push a count-2 bundle (uop_2=20'h0A001, uop_1=20'h7C002, uop_0=20'h00103) with exu_ready 1. Required: three consecutive cycles presenting 0A001/7C002/00103 with uop_step 2, 1, 0; uop_last asserted only on the third.
- Same count-2 bundle with hold high on the second issue cycle. Required: 7C002 is presented for 2 cycles, and the total bundle time is 4 cycles.
- Push three count-0 bundles back-to-back with exu_ready 0 (depth 2). Required: feed_req drops after 2 pushes and the third feed_ack is ignored. Then raise exu_ready: exactly 2 uops issue in order.
- Push a count-1 bundle and flush while step 1 is presented, with feed_ack high in the same cycle. Required: uop_valid 0 in the flush cycle and after it, occupancy 0, and the concurrent bundle is discarded.
- Push with uop_count_in=3. Required: seq_err rises and stays at 1; the bundle issues 3 uops (step 2, 1, 0).

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared micro-op width, field positions, bundle type and step encodings
package cpu_pkg;

  localparam int UOP_W = 20;

  localparam int UOP_ALU_HI       = 19;
  localparam int UOP_ALU_LO       = 16;
  localparam int UOP_CARRY_UNMASK = 15;
  localparam int UOP_LD           = 14;
  localparam int UOP_WR           = 13;
  localparam int UOP_WFLAGS       = 12;
  localparam int UOP_DEST_HI      = 11;
  localparam int UOP_DEST_LO      = 8;
  localparam int UOP_WB           = 7;
  localparam int UOP_SEL_K        = 6;
  localparam int UOP_REGB_HI      = 5;
  localparam int UOP_REGB_LO      = 3;
  localparam int UOP_REGA_HI      = 2;
  localparam int UOP_REGA_LO      = 0;

  localparam logic [1:0] STEP_PTR = 2'd2;
  localparam logic [1:0] STEP_IDX = 2'd1;
  localparam logic [1:0] STEP_FIN = 2'd0;

  typedef logic [UOP_W-1:0] uop_t;

  typedef struct packed {
    uop_t       uop_2;
    uop_t       uop_1;
    uop_t       uop_0;
    logic [1:0] step;
  } bundle_t;

  // An illegal count of 3 is issued as a full three-op bundle.
  function automatic logic [1:0] count_to_step(input logic [1:0] count);
    return (count == 2'd3) ? STEP_PTR : count;
  endfunction

endpackage

// File: rtl/uop_bundle_fifo.sv
// rtl/uop_bundle_fifo.sv - bundle storage with per-entry step counter, depth 1 or 2
module uop_bundle_fifo
  import cpu_pkg::*;
#(
  parameter int UOP_W = cpu_pkg::UOP_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             flush,
  input  logic             push,
  input  logic [UOP_W-1:0] push_uop_0,
  input  logic [UOP_W-1:0] push_uop_1,
  input  logic [UOP_W-1:0] push_uop_2,
  input  logic [1:0]       push_step,
  input  logic             advance,
  output logic [UOP_W-1:0] head_uop_0,
  output logic [UOP_W-1:0] head_uop_1,
  output logic [UOP_W-1:0] head_uop_2,
  output logic [1:0]       head_step,
  output logic [1:0]       occupancy
);

  logic [UOP_W-1:0] mem_0 [DEPTH];
  logic [UOP_W-1:0] mem_1 [DEPTH];
  logic [UOP_W-1:0] mem_2 [DEPTH];
  logic [1:0]       mem_step [DEPTH];
  logic             head_ptr;
  logic             tail_ptr;
  logic             pop;

  function automatic logic ptr_inc(input logic ptr);
    return (DEPTH == 1) ? 1'b0 : ~ptr;
  endfunction

  assign head_uop_0 = mem_0[head_ptr];
  assign head_uop_1 = mem_1[head_ptr];
  assign head_uop_2 = mem_2[head_ptr];
  assign head_step  = mem_step[head_ptr];
  assign pop        = advance && (head_step == STEP_FIN);

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      head_ptr  <= 1'b0;
      tail_ptr  <= 1'b0;
      occupancy <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem_step[i] <= STEP_FIN;
    end else if (flush) begin
      head_ptr  <= 1'b0;
      tail_ptr  <= 1'b0;
      occupancy <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem_step[i] <= STEP_FIN;
    end else begin
      if (push) begin
        mem_step[tail_ptr] <= push_step;
        tail_ptr           <= ptr_inc(tail_ptr);
      end
      // Head and tail never alias here: a push into an empty queue sees no advance.
      if (advance) begin
        if (pop) head_ptr <= ptr_inc(head_ptr);
        else     mem_step[head_ptr] <= head_step - 2'd1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_0[tail_ptr] <= push_uop_0;
      mem_1[tail_ptr] <= push_uop_1;
      mem_2[tail_ptr] <= push_uop_2;
    end
  end

endmodule

// File: rtl/uop_sequencer.sv
// rtl/uop_sequencer.sv - issues buffered micro-op bundles to execute, address-generation first
module uop_sequencer
  import cpu_pkg::*;
#(
  parameter int UOP_W       = cpu_pkg::UOP_W,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             flush,
  input  logic             hold,
  output logic             feed_req,
  input  logic             feed_ack,
  input  logic [UOP_W-1:0] uop_in_0,
  input  logic [UOP_W-1:0] uop_in_1,
  input  logic [UOP_W-1:0] uop_in_2,
  input  logic [1:0]       uop_count_in,
  input  logic             exu_ready,
  output logic             uop_valid,
  output logic [UOP_W-1:0] uop_out,
  output logic [1:0]       uop_step,
  output logic             uop_last,
  output logic             busy,
  output logic             seq_err
);

  localparam logic [1:0] DEPTH_L = QUEUE_DEPTH[1:0];

  logic [UOP_W-1:0] head_uop_0;
  logic [UOP_W-1:0] head_uop_1;
  logic [UOP_W-1:0] head_uop_2;
  logic [1:0]       head_step;
  logic [1:0]       occupancy;
  logic             push;
  logic             transfer;

  // feed_req depends only on registered occupancy and flush, never on exu_ready/hold.
  assign feed_req  = (occupancy < DEPTH_L) && !flush;
  assign push      = feed_ack && feed_req;
  assign uop_valid = (occupancy != 2'd0) && !flush;
  assign transfer  = uop_valid && exu_ready && !hold;
  assign busy      = (occupancy != 2'd0);

  uop_bundle_fifo #(
    .UOP_W (UOP_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .a_rst      (a_rst),
    .flush      (flush),
    .push       (push),
    .push_uop_0 (uop_in_0),
    .push_uop_1 (uop_in_1),
    .push_uop_2 (uop_in_2),
    .push_step  (count_to_step(uop_count_in)),
    .advance    (transfer),
    .head_uop_0 (head_uop_0),
    .head_uop_1 (head_uop_1),
    .head_uop_2 (head_uop_2),
    .head_step  (head_step),
    .occupancy  (occupancy)
  );

  always_comb begin
    uop_out  = '0;
    uop_step = STEP_FIN;
    uop_last = 1'b0;
    if (uop_valid) begin
      uop_step = head_step;
      uop_last = (head_step == STEP_FIN);
      case (head_step)
        STEP_PTR: uop_out = head_uop_2;
        STEP_IDX: uop_out = head_uop_1;
        default:  uop_out = head_uop_0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst)                              seq_err <= 1'b0;
    else if (push && uop_count_in == 2'd3)   seq_err <= 1'b1;
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// tb/tb_uop_sequencer.sv - scoreboard bench for uop_sequencer
module tb_uop_sequencer;

  localparam int UOP_W = 20;

  logic             clk = 1'b0;
  logic             a_rst = 1'b0;
  logic             flush = 1'b0;
  logic             hold = 1'b0;
  logic             feed_ack = 1'b0;
  logic             exu_ready = 1'b0;
  logic [UOP_W-1:0] uop_in_0 = '0;
  logic [UOP_W-1:0] uop_in_1 = '0;
  logic [UOP_W-1:0] uop_in_2 = '0;
  logic [1:0]       uop_count_in = 2'd0;
  logic             feed_req;
  logic             uop_valid;
  logic [UOP_W-1:0] uop_out;
  logic [1:0]       uop_step;
  logic             uop_last;
  logic             busy;
  logic             seq_err;

  uop_sequencer #(.UOP_W(UOP_W), .QUEUE_DEPTH(2)) dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .flush        (flush),
    .hold         (hold),
    .feed_req     (feed_req),
    .feed_ack     (feed_ack),
    .uop_in_0     (uop_in_0),
    .uop_in_1     (uop_in_1),
    .uop_in_2     (uop_in_2),
    .uop_count_in (uop_count_in),
    .exu_ready    (exu_ready),
    .uop_valid    (uop_valid),
    .uop_out      (uop_out),
    .uop_step     (uop_step),
    .uop_last     (uop_last),
    .busy         (busy),
    .seq_err      (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [UOP_W-1:0] uop;
    logic [1:0]       step;
    logic             last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   xfers = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_rst && uop_valid && exu_ready && !hold) begin
      checks++;
      xfers++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got uop %05h step %0d, nothing expected", uop_out, uop_step);
      end else begin
        mon_e = sb.pop_front();
        if (uop_out !== mon_e.uop || uop_step !== mon_e.step || uop_last !== mon_e.last) begin
          errors++;
          $display("FAIL issue: got uop %05h step %0d last %0b expected uop %05h step %0d last %0b",
                   uop_out, uop_step, uop_last, mon_e.uop, mon_e.step, mon_e.last);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [UOP_W-1:0] u2, input logic [UOP_W-1:0] u1,
                      input logic [UOP_W-1:0] u0, input logic [1:0] cnt,
                      input logic exp_accept, input string name);
    exp_t e;
    int   s;
    uop_in_2 = u2;
    uop_in_1 = u1;
    uop_in_0 = u0;
    uop_count_in = cnt;
    feed_ack = 1'b1;
    @(negedge clk);
    check({name, "_feed_req"}, feed_req, exp_accept);
    if (exp_accept) begin
      s = (cnt == 2'd3) ? 2 : int'(cnt);
      for (int st = s; st >= 0; st--) begin
        e.uop  = (st == 2) ? u2 : ((st == 1) ? u1 : u0);
        e.step = st[1:0];
        e.last = (st == 0);
        sb.push_back(e);
      end
    end
    sync();
    feed_ack = 1'b0;
  endtask

  // Counts cycles until busy drops; hold is raised on drain cycle hold_at (1-based).
  task automatic drain(input int hold_at, input logic [UOP_W-1:0] tgt, input string name,
                       output int n, output int n_tgt);
    n = 0;
    n_tgt = 0;
    hold = (hold_at == 1);
    while (1) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (uop_valid && uop_out == tgt) n_tgt++;
      if (n >= 20) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
        break;
      end
      sync();
      hold = (n + 1 == hold_at);
    end
    hold = 1'b0;
    sync();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int n, n_tgt, x0;

    #2;
    check("rst_uop_valid", uop_valid, 1'b0);
    check("rst_uop_out", uop_out, 20'h0);
    check("rst_uop_step", uop_step, 2'd0);
    check("rst_uop_last", uop_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_feed_req", feed_req, 1'b1);
    check("rst_seq_err", seq_err, 1'b0);
    sync();
    a_rst = 1'b1;
    sync();

    exu_ready = 1'b1;
    x0 = xfers;
    push(20'h0, 20'h0, 20'h70123, 2'd0, 1'b1, "t1");
    drain(0, 20'h70123, "t1", n, n_tgt);
    check("t1_cycles", n, 1);
    check("t1_xfers", xfers - x0, 1);

    x0 = xfers;
    push(20'h0A001, 20'h7C002, 20'h00103, 2'd2, 1'b1, "t2");
    drain(0, 20'h7C002, "t2", n, n_tgt);
    check("t2_cycles", n, 3);
    check("t2_xfers", xfers - x0, 3);

    x0 = xfers;
    push(20'h0A001, 20'h7C002, 20'h00103, 2'd2, 1'b1, "t3");
    drain(2, 20'h7C002, "t3", n, n_tgt);
    check("t3_cycles", n, 4);
    check("t3_idx_cycles", n_tgt, 2);
    check("t3_xfers", xfers - x0, 3);

    exu_ready = 1'b0;
    x0 = xfers;
    push(20'h0, 20'h0, 20'h11110, 2'd0, 1'b1, "t4a");
    push(20'h0, 20'h0, 20'h22220, 2'd0, 1'b1, "t4b");
    push(20'h0, 20'h0, 20'h33330, 2'd0, 1'b0, "t4c");
    @(negedge clk);
    check("t4_busy", busy, 1'b1);
    check("t4_no_issue", xfers - x0, 0);
    sync();
    exu_ready = 1'b1;
    drain(0, 20'h33330, "t4", n, n_tgt);
    check("t4_cycles", n, 2);
    check("t4_xfers", xfers - x0, 2);

    x0 = xfers;
    for (int i = 0; i < 4; i++) push(20'h0, 20'h0, 20'h40000 + i, 2'd0, 1'b1, "tput");
    drain(0, 20'h0, "tput", n, n_tgt);
    check("tput_tail_cycles", n, 1);
    check("tput_xfers", xfers - x0, 4);

    push(20'h0, 20'h2A0A1, 20'h2A0A0, 2'd1, 1'b1, "t5");
    flush = 1'b1;
    feed_ack = 1'b1;
    uop_in_0 = 20'h5A5A5;
    uop_count_in = 2'd0;
    @(negedge clk);
    check("t5_flush_valid", uop_valid, 1'b0);
    check("t5_flush_feed_req", feed_req, 1'b0);
    sb.delete();
    sync();
    flush = 1'b0;
    feed_ack = 1'b0;
    @(negedge clk);
    check("t5_post_valid", uop_valid, 1'b0);
    check("t5_post_busy", busy, 1'b0);
    sync();
    @(negedge clk);
    check("t5_dropped_busy", busy, 1'b0);
    sync();

    check("t6_pre_seq_err", seq_err, 1'b0);
    x0 = xfers;
    push(20'h3C003, 20'h3C002, 20'h3C001, 2'd3, 1'b1, "t6");
    drain(0, 20'h3C002, "t6", n, n_tgt);
    check("t6_cycles", n, 3);
    check("t6_xfers", xfers - x0, 3);
    check("t6_seq_err", seq_err, 1'b1);
    sync();
    sync();
    check("t6_seq_err_sticky", seq_err, 1'b1);

    push(20'h0B002, 20'h0B001, 20'h0B000, 2'd2, 1'b1, "t7");
    sync();
    #2;
    a_rst = 1'b0;
    #1;
    sb.delete();
    check("t7_rst_busy", busy, 1'b0);
    check("t7_rst_valid", uop_valid, 1'b0);
    check("t7_rst_step", uop_step, 2'd0);
    check("t7_rst_seq_err", seq_err, 1'b0);
    sync();
    a_rst = 1'b1;
    @(negedge clk);
    check("t7_after_busy", busy, 1'b0);
    check("t7_after_feed_req", feed_req, 1'b1);
    sync();

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
